// File: rtl/urna_pkg.sv
// Shared definitions for the multi-candidate ballot box.
package urna_pkg;

  // Ballot box controller states; encodings are visible on the estado port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COUNT   = 2'd2,
    ST_CLOSED  = 2'd3
  } state_e;

  // Keypad code that registers a blank vote.
  localparam int unsigned BLANK_CODE = 0;

endpackage

// File: rtl/urna_counter.sv
// Saturating tally counter: counts inc pulses and stops at all-ones.
module urna_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: increment unless already at the maximum value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Counters never decrement, so reaching the maximum is inherently sticky.
  assign sat_o   = (count_q == '1);

endmodule

// File: rtl/urna_multi.sv
// Multi-candidate electronic ballot box: captures, confirms and tallies votes,
// then on close scans the candidate tallies serially to pick a winner.
module urna_multi
  import urna_pkg::*;
#(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CODE_W-1:0]         code,
  input  logic                      valid,
  input  logic                      confirm,
  input  logic                      swap,
  input  logic                      finish,
  output logic [1:0]                estado,
  output logic                      vote_status,
  output logic [NUM_CAND*CNT_W-1:0] totals,
  output logic [CNT_W-1:0]          total_blank,
  output logic [CNT_W-1:0]          total_null,
  output logic                      sat,
  output logic [CODE_W-1:0]         winner,
  output logic                      tie,
  output logic                      result_valid
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              vote_status_q, vote_status_d;
  logic              commit;

  logic [NUM_CAND-1:0] inc_cand;
  logic                inc_blank;
  logic                inc_null;
  logic [CNT_W-1:0]    cand_cnt [NUM_CAND];
  logic [NUM_CAND+1:0] sat_vec;

  logic              scanning_q, scanning_d;
  logic [CODE_W-1:0] scan_idx_q, scan_idx_d;
  logic [CODE_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0]  best_q, best_d;
  logic              tie_acc_q, tie_acc_d;
  logic              result_valid_q, result_valid_d;
  logic [CODE_W-1:0] winner_q, winner_d;
  logic              tie_q, tie_d;
  logic [CNT_W-1:0]  scan_val;

  // Next state and code capture; finish overrides every other request.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (finish) begin
      state_d = ST_CLOSED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            state_d = ST_PENDING;
            code_d  = code;
          end
        end
        ST_PENDING: begin
          if (confirm) begin
            state_d = ST_COUNT;
          end else if (swap) begin
            state_d = ST_IDLE;
          end
        end
        ST_COUNT:  state_d = ST_IDLE;
        ST_CLOSED: state_d = ST_CLOSED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // A vote commits on the edge that leaves COUNT unless finish is sampled there.
  always_comb begin
    commit        = (state_q == ST_COUNT) && !finish;
    vote_status_d = commit;
  end

  // Classify the latched code into candidate, blank or null increments.
  always_comb begin
    inc_cand  = '0;
    inc_blank = 1'b0;
    inc_null  = 1'b0;
    if (commit) begin
      if (code_q == CODE_W'(BLANK_CODE)) begin
        inc_blank = 1'b1;
      end else if (code_q > CODE_W'(NUM_CAND)) begin
        inc_null = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
          if (code_q == CODE_W'(i + 1)) begin
            inc_cand[i] = 1'b1;
          end
        end
      end
    end
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      code_q        <= '0;
      vote_status_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      vote_status_q <= vote_status_d;
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    urna_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (inc_cand[g]),
      .count_o(cand_cnt[g]),
      .sat_o  (sat_vec[g])
    );
    assign totals[g*CNT_W +: CNT_W] = cand_cnt[g];
  end

  urna_counter #(.CNT_W(CNT_W)) u_blank (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc_blank),
    .count_o(total_blank),
    .sat_o  (sat_vec[NUM_CAND])
  );

  urna_counter #(.CNT_W(CNT_W)) u_null (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc_null),
    .count_o(total_null),
    .sat_o  (sat_vec[NUM_CAND+1])
  );

  // Select the tally under inspection for the single shared comparator.
  always_comb begin
    scan_val = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (scan_idx_q == CODE_W'(i)) begin
        scan_val = cand_cnt[i];
      end
    end
  end

  // Serial winner scan: one candidate per cycle, started on entry to CLOSED.
  always_comb begin
    scanning_d     = scanning_q;
    scan_idx_d     = scan_idx_q;
    best_d         = best_q;
    best_idx_d     = best_idx_q;
    tie_acc_d      = tie_acc_q;
    result_valid_d = result_valid_q;
    winner_d       = winner_q;
    tie_d          = tie_q;
    if (finish && (state_q != ST_CLOSED)) begin
      scanning_d     = 1'b1;
      scan_idx_d     = '0;
      best_d         = '0;
      best_idx_d     = '0;
      tie_acc_d      = 1'b0;
      result_valid_d = 1'b0;
      winner_d       = '0;
      tie_d          = 1'b0;
    end else if (scanning_q) begin
      // Index 0 seeds the best; later strictly greater tallies replace it,
      // so equal tallies keep the lowest index and only flag a tie.
      if ((scan_idx_q == '0) || (scan_val > best_q)) begin
        best_d     = scan_val;
        best_idx_d = scan_idx_q;
        tie_acc_d  = 1'b0;
      end else if (scan_val == best_q) begin
        tie_acc_d = 1'b1;
      end
      scan_idx_d = scan_idx_q + 1'b1;
      if (scan_idx_q == CODE_W'(NUM_CAND - 1)) begin
        scanning_d     = 1'b0;
        result_valid_d = 1'b1;
        winner_d       = (best_d == '0) ? '0 : best_idx_d + 1'b1;
        tie_d          = tie_acc_d | (best_d == '0);
      end
    end
  end

  // Scan registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanning_q     <= 1'b0;
      scan_idx_q     <= '0;
      best_q         <= '0;
      best_idx_q     <= '0;
      tie_acc_q      <= 1'b0;
      result_valid_q <= 1'b0;
      winner_q       <= '0;
      tie_q          <= 1'b0;
    end else begin
      scanning_q     <= scanning_d;
      scan_idx_q     <= scan_idx_d;
      best_q         <= best_d;
      best_idx_q     <= best_idx_d;
      tie_acc_q      <= tie_acc_d;
      result_valid_q <= result_valid_d;
      winner_q       <= winner_d;
      tie_q          <= tie_d;
    end
  end

  assign estado       = state_q;
  assign vote_status  = vote_status_q;
  assign sat          = |sat_vec;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_urna_multi.sv
// Bench for urna_multi: default instance plus a CNT_W=2 instance on shared stimulus.
module tb_urna_multi;

  localparam int NC = 4;
  localparam int CW = 4;
  localparam int W1 = 8;
  localparam int W2 = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] code = '0;
  logic          valid = 1'b0, confirm = 1'b0, swap = 1'b0, finish = 1'b0;

  logic [1:0]       a_est, b_est;
  logic             a_vs, b_vs, a_sat, b_sat, a_tie, b_tie, a_rv, b_rv;
  logic [NC*W1-1:0] a_tot;
  logic [NC*W2-1:0] b_tot;
  logic [W1-1:0]    a_blk, a_nul;
  logic [W2-1:0]    b_blk, b_nul;
  logic [CW-1:0]    a_win, b_win;

  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;
  int pulses_base;

  // Model state: spec-level phase, latched code, raw (unsaturated) tallies.
  int m_state = 0, m_code = 0, m_vs = 0, m_scan = 0;
  int m_cand [NC];
  int m_blank = 0, m_null = 0;

  always #5 clk = ~clk;

  urna_multi #(.NUM_CAND(NC), .CODE_W(CW), .CNT_W(W1)) u_dut (
    .clk(clk), .rst_n(rst_n), .code(code), .valid(valid), .confirm(confirm),
    .swap(swap), .finish(finish), .estado(a_est), .vote_status(a_vs),
    .totals(a_tot), .total_blank(a_blk), .total_null(a_nul), .sat(a_sat),
    .winner(a_win), .tie(a_tie), .result_valid(a_rv)
  );

  urna_multi #(.NUM_CAND(NC), .CODE_W(CW), .CNT_W(W2)) u_sat (
    .clk(clk), .rst_n(rst_n), .code(code), .valid(valid), .confirm(confirm),
    .swap(swap), .finish(finish), .estado(b_est), .vote_status(b_vs),
    .totals(b_tot), .total_blank(b_blk), .total_null(b_nul), .sat(b_sat),
    .winner(b_win), .tie(b_tie), .result_valid(b_rv)
  );

  // Behavioural model of the election rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_code <= 0; m_vs <= 0; m_scan <= 0;
      m_blank <= 0; m_null <= 0;
      for (int i = 0; i < NC; i++) m_cand[i] <= 0;
    end else begin
      m_vs <= 0;
      if (m_state == 3 && m_scan < NC) m_scan <= m_scan + 1;
      if (finish) begin
        if (m_state != 3) begin
          m_state <= 3;
          m_scan  <= 0;
        end
      end else begin
        case (m_state)
          0: if (valid) begin m_code <= int'(code); m_state <= 1; end
          1: if (confirm) m_state <= 2; else if (swap) m_state <= 0;
          2: begin
            if (m_code == 0) m_blank <= m_blank + 1;
            else if (m_code <= NC) m_cand[m_code-1] <= m_cand[m_code-1] + 1;
            else m_null <= m_null + 1;
            m_vs    <= 1;
            m_state <= 0;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic int sat_of(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Winner = first candidate holding the maximum tally; tie if the maximum is shared.
  task automatic exp_result(input int maxv, output int w, output int t);
    int best, first, cnt;
    best = 0; first = 0; cnt = 0;
    for (int i = 0; i < NC; i++) if (sat_of(m_cand[i], maxv) > best) best = sat_of(m_cand[i], maxv);
    for (int i = 0; i < NC; i++) begin
      if (sat_of(m_cand[i], maxv) == best) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    w = (best == 0) ? 0 : first + 1;
    t = (cnt > 1) ? 1 : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int w, input logic [31:0] tot,
                           input int est, input int vs, input int blk, input int nul,
                           input int st, input int win, input int ti, input int rv);
    int maxv, ew, et, erv, esat;
    maxv = (1 << w) - 1;
    erv  = (m_state == 3 && m_scan >= NC) ? 1 : 0;
    exp_result(maxv, ew, et);
    esat = (m_blank >= maxv || m_null >= maxv) ? 1 : 0;
    for (int i = 0; i < NC; i++) if (m_cand[i] >= maxv) esat = 1;
    chk({tag, ".estado"}, est, m_state);
    chk({tag, ".vote_status"}, vs, m_vs);
    for (int i = 0; i < NC; i++)
      chk($sformatf("%s.totals[%0d]", tag, i), int'((tot >> (i * w)) & 32'(maxv)),
          sat_of(m_cand[i], maxv));
    chk({tag, ".total_blank"}, blk, sat_of(m_blank, maxv));
    chk({tag, ".total_null"}, nul, sat_of(m_null, maxv));
    chk({tag, ".sat"}, st, esat);
    chk({tag, ".result_valid"}, rv, erv);
    chk({tag, ".winner"}, win, erv ? ew : 0);
    chk({tag, ".tie"}, ti, erv ? et : 0);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (a_vs) pulses <= pulses + 1;
    check_dut("a", W1, 32'(a_tot), int'(a_est), int'(a_vs), int'(a_blk), int'(a_nul),
              int'(a_sat), int'(a_win), int'(a_tie), int'(a_rv));
    check_dut("b", W2, 32'(b_tot), int'(b_est), int'(b_vs), int'(b_blk), int'(b_nul),
              int'(b_sat), int'(b_win), int'(b_tie), int'(b_rv));
  end

  function automatic int a_cand(input int i);
    return int'(a_tot[i*W1 +: W1]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    valid = 0; confirm = 0; swap = 0; finish = 0; code = '0;
    rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc(1);
  endtask

  task automatic vote(input int c);
    valid = 1; code = CW'(c);
    cyc(1);
    valid = 0; confirm = 1;
    cyc(1);
    confirm = 0;
    cyc(2);
  endtask

  task automatic close_and_scan();
    finish = 1;
    cyc(1);
    finish = 0;
    cyc(NC);
  endtask

  initial begin
    #1 rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc(1);

    // Session 1: vote sequence 3,3,4,0,7 with latency checks on the first vote.
    chk("reset_estado", int'(a_est), 0);
    chk("reset_rv", int'(a_rv), 0);
    pulses_base = pulses;
    valid = 1; code = 4'd3;
    cyc(1);
    chk("lat_pending", int'(a_est), 1);
    valid = 0; confirm = 1;
    cyc(1);
    chk("lat_count_state", int'(a_est), 2);
    chk("lat_no_pulse_yet", int'(a_vs), 0);
    chk("lat_tally_before", a_cand(2), 0);
    confirm = 0;
    cyc(1);
    chk("lat_pulse", int'(a_vs), 1);
    chk("lat_tally_after", a_cand(2), 1);
    cyc(1);
    chk("lat_idle", int'(a_est), 0);
    chk("lat_pulse_gone", int'(a_vs), 0);
    vote(3); vote(4); vote(0); vote(7);
    chk("seq_pulses", pulses - pulses_base, 5);
    chk("seq_cand3", a_cand(2), 2);
    chk("seq_cand4", a_cand(3), 1);
    chk("seq_cand1", a_cand(0), 0);
    chk("seq_blank", int'(a_blk), 1);
    chk("seq_null", int'(a_nul), 1);
    close_and_scan();
    chk("seq_rv", int'(a_rv), 1);
    chk("seq_winner", int'(a_win), 3);
    chk("seq_tie", int'(a_tie), 0);

    // Session 2: captured vote swapped away, then close with no votes.
    do_reset();
    valid = 1; code = 4'd2;
    cyc(1);
    valid = 0; swap = 1;
    cyc(1);
    swap = 0;
    chk("swap_idle", int'(a_est), 0);
    finish = 1;
    cyc(1);
    chk("swap_closed", int'(a_est), 3);
    cyc(1);
    finish = 0;
    cyc(2);
    chk("empty_rv_early", int'(a_rv), 0);
    cyc(1);
    chk("empty_rv", int'(a_rv), 1);
    chk("empty_winner", int'(a_win), 0);
    chk("empty_tie", int'(a_tie), 1);
    chk("swap_cand2", a_cand(1), 0);
    valid = 1; code = 4'd1; confirm = 1;
    cyc(3);
    valid = 0; confirm = 0;
    chk("closed_terminal", int'(a_est), 3);
    chk("closed_no_vote", a_cand(0), 0);

    // Session 3: two votes each for 1 and 2; one re-capture attempt while pending.
    do_reset();
    vote(1); vote(1);
    valid = 1; code = 4'd2;
    cyc(1);
    code = 4'd4; confirm = 1;
    cyc(1);
    valid = 0; confirm = 0;
    cyc(2);
    vote(2);
    chk("tie_cand2", a_cand(1), 2);
    chk("tie_cand4", a_cand(3), 0);
    close_and_scan();
    chk("tie_winner", int'(a_win), 1);
    chk("tie_flag", int'(a_tie), 1);

    // Session 4: saturation, then confirm and finish on the same edge.
    do_reset();
    repeat (5) vote(1);
    chk("sat_b_cand1", int'(b_tot[0 +: W2]), 3);
    chk("sat_b_flag", int'(b_sat), 1);
    chk("sat_a_cand1", a_cand(0), 5);
    chk("sat_a_flag", int'(a_sat), 0);
    valid = 1; code = 4'd2;
    cyc(1);
    valid = 0; confirm = 1; finish = 1;
    cyc(1);
    confirm = 0; finish = 0;
    chk("cf_estado", int'(a_est), 3);
    chk("cf_cand2", a_cand(1), 0);
    cyc(NC + 1);
    chk("sat_a_winner", int'(a_win), 1);
    chk("sat_b_winner", int'(b_win), 1);

    // Session 5: finish during COUNT discards the vote; reset mid-scan.
    do_reset();
    valid = 1; code = 4'd1;
    cyc(1);
    valid = 0; confirm = 1;
    cyc(1);
    confirm = 0; finish = 1;
    cyc(1);
    finish = 0;
    chk("fc_estado", int'(a_est), 3);
    chk("fc_cand1", a_cand(0), 0);
    chk("fc_no_pulse", int'(a_vs), 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_estado", int'(a_est), 0);
    chk("async_rv", int'(a_rv), 0);
    chk("async_winner", int'(a_win), 0);
    chk("async_tie", int'(a_tie), 0);
    chk("async_totals", int'(a_tot), 0);
    chk("async_b_estado", int'(b_est), 0);
    @(negedge clk);
    cyc(1);
    rst_n = 1;
    cyc(NC + 2);
    chk("abort_rv", int'(a_rv), 0);
    chk("abort_estado", int'(a_est), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/urna_multi.md
URNA_MULTI -- requirements
Module: urna_multi

Interface
REQ-001 Parameter NUM_CAND, default 4: number of candidates, range 2..15.
REQ-002 Parameter CODE_W, default 4: vote code width; SHALL satisfy 2^CODE_W > NUM_CAND.
REQ-003 Parameter CNT_W, default 8: width of every tally counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 code  in  CODE_W  vote code from the keypad.
REQ-007 valid  in  1  capture code.
REQ-008 confirm  in  1  commit the captured vote.
REQ-009 swap  in  1  discard the captured vote.
REQ-010 finish  in  1  close the election.
REQ-011 estado  out  2  current FSM state.
REQ-012 vote_status  out  1  one-cycle pulse per committed vote.
REQ-013 totals  out  NUM_CAND*CNT_W  packed per-candidate tallies; candidate i occupies bits [i*CNT_W +: CNT_W].
REQ-014 total_blank  out  CNT_W  blank-vote tally.
REQ-015 total_null  out  CNT_W  null-vote tally.
REQ-016 sat  out  1  sticky flag: some counter hit its maximum.
REQ-017 winner  out  CODE_W  winning candidate code (1-based); 0 when not valid.
REQ-018 tie  out  1  winner's tally is shared by at least one other candidate.
REQ-019 result_valid  out  1  winner and tie are final.

Function
REQ-020 States: IDLE=0, PENDING=1, COUNT=2, CLOSED=3.
REQ-021 IDLE: valid=1 latches code and goes to PENDING next edge.
REQ-022 PENDING: confirm=1 goes to COUNT.
REQ-023 PENDING: swap=1 with confirm=0 returns to IDLE; no tally change.
REQ-024 PENDING: valid is ignored; the latched code is not re-captured.
REQ-025 COUNT lasts exactly one cycle: increments one tally, drives vote_status=1, then returns to IDLE.
REQ-026 Code classification: 1..NUM_CAND counts for candidate code-1; 0 is blank; any other value is null.
REQ-027 Counters saturate at 2^CNT_W-1: no wrap; sat set and held.
REQ-028 finish=1 in any state moves to CLOSED next edge and overrides confirm, swap and valid.
REQ-029 A vote that is pending or in COUNT when finish is sampled is discarded.
REQ-030 CLOSED is terminal until reset; valid, confirm and swap are ignored there.
REQ-031 On entering CLOSED, a sequential scan visits one candidate per cycle, index 0 first.
REQ-032 Scan: a strictly greater tally replaces the best; an equal tally sets tie.
REQ-033 Scan result: ties resolve to the lowest index; result_valid asserts NUM_CAND cycles after entering CLOSED and holds.
REQ-034 If all candidate tallies are 0 at close: winner=0, tie=1.
REQ-035 Vote latency: confirm sampled at edge N; vote_status high and tally updated after edge N+1; IDLE after edge N+2.

Reset
REQ-036 rst_n=0 immediately forces state IDLE, all tallies 0, and sat, vote_status, winner, tie, result_valid and the latched code to 0.
REQ-037 Reset mid-scan or mid-vote aborts the operation with no partial result.
REQ-038 Reset release takes effect synchronously at the next rising edge.

Structure
REQ-039 Package urna_pkg SHALL hold the state encodings and the BLANK_CODE=0 constant.
REQ-040 Sub-module urna_counter SHALL implement one saturating CNT_W counter with inc and sat_o; it is instantiated NUM_CAND+2 times.
REQ-041 The scan SHALL use one comparator, not a NUM_CAND-wide combinational tree.

Verification (defaults unless noted)
REQ-042 Vote sequence 3,3,4,0,7, each as valid then confirm -> totals[2]=2, totals[3]=1, total_blank=1, total_null=1, five vote_status pulses.
REQ-043 valid code=2, then swap, then finish -> totals[1]=0; CLOSED; result_valid after 4 cycles; winner=0, tie=1.
REQ-044 Two votes each for candidates 1 and 2, then finish -> winner=1, tie=1.
REQ-045 CNT_W=2, five votes for candidate 1 -> totals[0]=3 and sat=1.
REQ-046 confirm and finish asserted on the same edge -> no tally change, estado=3.
REQ-047 rst_n pulsed low mid-scan -> estado=0, all outputs 0 asynchronously.
